// File: rtl/div_if.sv
// Handshake and result bundle between the EX stage and the divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] opdata1;
    logic [WIDTH-1:0] opdata2;
    logic             annul;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  busy, ready, result_hi, result_lo
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output busy, ready, result_hi, result_lo
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider feeding the HI/LO pair (DIV/DIVU).
// Quotient lands in result_lo, remainder in result_hi; ready pulses once
// per completed divide and busy covers the whole time a divide is in flight.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; operands latched on acceptance
// S_ON     | one quotient bit per cycle, WIDTH cycles total
// S_DIVZERO| zero divisor: skip the iterations, result fixed at zero
// S_END    | ready pulse; result registers already hold the answer
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ON      = 2'd1,
        S_DIVZERO = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_qneg;
    logic               r_rneg;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;

    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_dvd_next;

    // Operand magnitudes; 0x80000000 negates to itself, which is 2^31 unsigned.
    assign w_neg1 = bus.signed_div & bus.opdata1[WIDTH-1];
    assign w_neg2 = bus.signed_div & bus.opdata2[WIDTH-1];
    assign w_abs1 = w_neg1 ? (~bus.opdata1 + 1'b1) : bus.opdata1;
    assign w_abs2 = w_neg2 ? (~bus.opdata2 + 1'b1) : bus.opdata2;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.annul &&
                      (bus.opdata2 != '0);
    assign w_step   = (r_state == S_ON) && !bus.annul;
    assign w_last   = w_step && (r_cnt == CNT_W'(WIDTH - 1));

    // Partial remainder stays below the divisor, so after the shift a
    // successful trial subtraction always fits back into WIDTH bits.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_diff     = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_ge};

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.ready     = (r_state == S_END);
    assign bus.result_hi = r_res_hi;
    assign bus.result_lo = r_res_lo;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; annul only matters before the result is committed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.annul) begin
                    w_next = (bus.opdata2 == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_ON: begin
                if (bus.annul) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next = S_END;
                end
            end
            S_DIVZERO: w_next = S_END;
            S_END:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Working registers: latch magnitudes and signs on accept, iterate in ON.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_rem  <= '0;
            r_dvd  <= w_abs1;
            r_dvs  <= w_abs2;
            r_qneg <= w_neg1 ^ w_neg2;
            r_rneg <= w_neg1;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_rem  <= w_rem_next;
            r_dvd  <= w_dvd_next;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Result registers load on entry to END and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else if (w_last) begin
            r_res_lo <= r_qneg ? (~w_dvd_next + 1'b1) : w_dvd_next;
            r_res_hi <= r_rneg ? (~w_rem_next + 1'b1) : w_rem_next;
        end else if (r_state == S_DIVZERO) begin
            r_res_lo <= '0;
            r_res_hi <= '0;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with an arithmetic reference model.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic [63:0] pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: {remainder, quotient} from plain 64-bit integer arithmetic.
    function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Every cycle: consume a model result on ready, and require HI/LO to match.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ready) begin
                total++;
                if (pend.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready actual=1 required=0");
                end else begin
                    {exp_hi, exp_lo} = pend.pop_front();
                end
            end
            check("model_hi", bus.result_hi, exp_hi);
            check("model_lo", bus.result_lo, exp_lo);
        end
    end

    task automatic drive_start(input bit sd, input logic [31:0] a, input logic [31:0] b);
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        pend.push_back(model(sd, a, b));
    endtask

    // Issue one divide and check busy/ready per cycle plus literal results.
    task automatic run_div(input string name, input bit sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi_lit,
                           input logic [31:0] lo_lit, input int lat,
                           input bit no_wait, input bit poke);
        if (!no_wait) @(negedge clk);
        drive_start(sd, a, b);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (poke && c == 5) begin
                bus.start   = 1'b1;
                bus.opdata1 = 32'd50;
                bus.opdata2 = 32'd5;
            end
            if (poke && c == 6) bus.start = 1'b0;
            check({name, "_busy"}, {31'd0, bus.busy}, {31'd0, (c <= lat)});
            check({name, "_ready"}, {31'd0, bus.ready}, {31'd0, (c == lat)});
            if (c == lat) begin
                check({name, "_lo"}, bus.result_lo, lo_lit);
                check({name, "_hi"}, bus.result_hi, hi_lit);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;
        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_hi", bus.result_hi, 32'd0);
        check("rst_lo", bus.result_lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7",  1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0, 1'b0);
        run_div("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 1'b0);
        run_div("div_7_m2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b0, 1'b0);
        run_div("divu_big_2",  1'b0, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 33, 1'b0, 1'b0);
        run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       33, 1'b0, 1'b0);
        run_div("div_zero",    1'b1, 32'd1234,     32'd0,        32'd0,        32'd0,         2, 1'b0, 1'b0);
        run_div("div_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 1'b0, 1'b0);
        run_div("busy_start",  1'b0, 32'd1000,     32'd9,        32'd1,        32'd111,      33, 1'b0, 1'b1);

        // Annul mid-divide: no ready, results hold, restart in the very next cycle.
        @(negedge clk);
        drive_start(1'b0, 32'd100, 32'd7);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            check("annul_busy", {31'd0, bus.busy}, 32'd1);
            check("annul_ready", {31'd0, bus.ready}, 32'd0);
            if (c == 10) bus.annul = 1'b1;
        end
        @(negedge clk);
        bus.annul = 1'b0;
        check("annul_idle", {31'd0, bus.busy}, 32'd0);
        check("annul_keep_lo", bus.result_lo, 32'd111);
        void'(pend.pop_back());
        run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 33, 1'b1, 1'b0);

        // Asynchronous reset in the middle of ON.
        @(negedge clk);
        drive_start(1'b0, 32'd1000, 32'd3);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_ready", {31'd0, bus.ready}, 32'd0);
        check("arst_hi", bus.result_hi, 32'd0);
        check("arst_lo", bus.result_lo, 32'd0);
        pend.delete();
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("arst_no_ready", {31'd0, bus.ready}, 32'd0);
        end

        run_div("post_rst", 1'b0, 32'd81, 32'd9, 32'd0, 32'd9, 33, 1'b0, 1'b0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
